wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone classic arbiter with a bus-timeout watchdog. It shares one slave-side bus (the peripheral segment carrying the GPIO and similar register slaves) between master 0 (CPU data port) and master 1 (debug/DMA port). Arbitration is round-robin on CYC_I. A stalled slave produces an error termination instead of hanging the granted master.

## Interface
Parameters:
- TIMEOUT, 255: number of unacknowledged strobe cycles before an error termination; range 2..65535.
- CW, 16: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- m0_adr_i / m1_adr_i  in  32  master address
- m0_dat_i / m1_dat_i  in  32  master write data
- m0_sel_i / m1_sel_i  in  4  byte selects
- m0_we_i / m1_we_i  in  1  write enable
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_cyc_i / m1_cyc_i  in  1  cycle / bus request
- m0_dat_o / m1_dat_o  out  32  read data (s_dat_i when granted, else 0)
- m0_ack_o / m1_ack_o  out  1  acknowledge
- m0_err_o / m1_err_o  out  1  timeout error termination
- s_adr_o, s_dat_o, s_sel_o, s_we_o  out  32/32/4/1  muxed from the granted master; 0 when idle
- s_stb_o, s_cyc_o  out  1  gated by grant and error
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave acknowledge
- grant_o  out  2  one-hot grant status (bit0 = m0, bit1 = m1)

## Operation
- FSM states: IDLE, GNT0, GNT1. A registered `last` bit holds the master served most recently and resets to 1, so m0 wins the first tie.
- IDLE:
  - Only m0_cyc_i high: go to GNT0.
  - Only m1_cyc_i high: go to GNT1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in IDLE.
- GNTx:
  - Hold the grant while mx_cyc_i is high. No preemption, so multi-transfer cycles are preserved.
  - When mx_cyc_i is low: go to IDLE and set `last` = x.
- Slave-side mux is combinational from the FSM state:
  - s_cyc_o = mx_cyc_i & granted.
  - s_stb_o = mx_stb_i & granted & ~err_now.
  - Address, data, sel and we come from the granted master; all zero in IDLE.
- Response routing:
  - mx_ack_o = s_ack_i & granted(x).
  - mx_dat_o = s_dat_i when granted(x), else 0.
  - The non-granted master never sees ack or err.
- Watchdog:
  - cnt (CW bits) increments each cycle with s_cyc_o & mx_stb_i & ~s_ack_i.
  - cnt clears on s_ack_i, on stb low, on leaving GNTx, and in the cycle after err.
  - err_now = (cnt == TIMEOUT). When err_now, mx_err_o = 1 for exactly that cycle and s_stb_o is forced 0.
  - If s_ack_i = 1 in the same cycle, ack wins: err is suppressed and cnt clears.
- Reset (any time, including mid-transfer): state = IDLE, `last` = 1, cnt = 0. All outputs are 0 asynchronously, including grant_o = 00.

## Timing
- Arbitration latency: from the cycle cyc rises in IDLE, s_cyc_o and s_stb_o first assert on the next clock edge (1 cycle).
- Data path: mux and ack/err/dat routing are combinational; the arbiter adds no pipeline stage.
- Release: cycle n has mx_cyc_i = 0 in GNTx. Cycle n+1 is IDLE, with s_cyc_o = 0 and the FSM re-arbitrating. The earliest new grant is visible in cycle n+2. This one-cycle bus turnaround is mandatory.
- Registered slave acking one cycle after stb (e.g. GPIO register block): a single transfer completes in 2 cycles after grant.
- Error timing: with stb held and no ack, err asserts in the TIMEOUT+1-th cycle of the strobe (cnt = 0..TIMEOUT).
- After err: the master may keep cyc and issue a new stb; cnt restarts from 0.
- grant_o is a direct decode of the state register, so it is glitch-free.

## Test plan
- Single master:
  - Stimulus: m0 writes adr 0x1, dat 0x1 to a slave acking one cycle after stb.
  - Response: grant_o = 01 one cycle after cyc; m0_ack_o one pulse; m1 outputs stay 0; IDLE one cycle after cyc drops.
- Tie after reset:
  - Stimulus: m0 and m1 raise cyc in the same cycle.
  - Response: m0 is granted first. After m0 drops cyc: one IDLE cycle, then grant_o = 10. With both re-requesting, grants alternate 01, 10, 01.
- Held grant:
  - Stimulus: m1 holds cyc for 4 back-to-back reads while m0 requests.
  - Response: all 4 reads complete on m1 with m1_dat_o = s_dat_i; m0 is granted only after m1 releases.
- Timeout:
  - Stimulus: TIMEOUT = 4; slave never acks; m0 holds stb.
  - Response: m0_err_o = 1 in exactly the 5th strobe cycle with s_stb_o = 0 that cycle; m0_ack_o never asserts; cnt restarts afterwards.
- Ack/err collision:
  - Stimulus: TIMEOUT = 4; s_ack_i arrives in the cycle cnt == 4.
  - Response: m0_ack_o = 1 and m0_err_o = 0.
- Reset mid-transfer:
  - Stimulus: assert rst_n low while in GNT1 with stb high.
  - Response: grant_o = 00, s_cyc_o = 0, s_stb_o = 0 immediately (asynchronously). After release, a simultaneous request grants m0 first.

Source files
------------

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone classic arbiter with a bus-timeout watchdog.
//
// Shares one slave-side bus between master 0 (CPU data port) and master 1
// (debug/DMA port). Arbitration is round-robin on cyc; a granted master keeps
// the bus until it drops cyc. A slave that never acks is terminated with a
// one-cycle error pulse after TIMEOUT unacknowledged strobe cycles.
//
// Parameters:
//   TIMEOUT  unacked strobe cycles before an error termination (2..65535)
//   CW       watchdog counter width, 2^CW > TIMEOUT
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mX_adr/dat/sel/we/stb/cyc_i   master X request
//   mX_dat_o/ack_o/err_o     master X response (zero unless X is granted)
//   s_adr/dat/sel/we_o       muxed from granted master, zero when idle
//   s_stb_o, s_cyc_o         gated by grant (stb also by error)
//   s_dat_i, s_ack_i         slave response
//   grant_o                  one-hot grant, bit0 = m0, bit1 = m1

module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic gnt0, gnt1;
    logic cyc_sel, stb_sel;
    logic err_now;

    assign gnt0 = (state_q == StGnt0);
    assign gnt1 = (state_q == StGnt1);

    // Round-robin arbitration; a grant is only released when its cyc drops.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    state_d = StIdle;
                    last_d  = 1'b0;
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    state_d = StIdle;
                    last_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request mux from the granted master; everything zero when idle.
    always_comb begin
        cyc_sel = 1'b0;
        stb_sel = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        if (gnt0) begin
            cyc_sel = m0_cyc_i;
            stb_sel = m0_stb_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
        end else if (gnt1) begin
            cyc_sel = m1_cyc_i;
            stb_sel = m1_stb_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
        end
    end

    // The error fires only on a live strobe, and an ack in the same cycle wins.
    assign err_now = cyc_sel & stb_sel & ~s_ack_i & (cnt_q == CW'(TIMEOUT));

    // Count only unacked strobe cycles; any ack, idle strobe, release or error
    // restarts the count from zero.
    assign cnt_d = (cyc_sel & stb_sel & ~s_ack_i & ~err_now) ? cnt_q + CW'(1) : '0;

    assign s_cyc_o = cyc_sel;
    assign s_stb_o = stb_sel & ~err_now;

    assign m0_ack_o = s_ack_i & gnt0;
    assign m1_ack_o = s_ack_i & gnt1;
    assign m0_err_o = err_now & gnt0;
    assign m1_err_o = err_now & gnt1;
    assign m0_dat_o = gnt0 ? s_dat_i : '0;
    assign m1_dat_o = gnt1 ? s_dat_i : '0;

    assign grant_o = {gnt1, gnt0};

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic [3:0]  msel [2];
    logic        mwe  [2];
    logic        mc   [2];
    logic        ms   [2];
    logic [31:0] sdat;
    logic        sack;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic [1:0]  grant_o;

    wb_arbiter2 #(.TIMEOUT(T), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_adr_i (madr[0]),
        .m0_dat_i (mdat[0]),
        .m0_sel_i (msel[0]),
        .m0_we_i  (mwe[0]),
        .m0_stb_i (ms[0]),
        .m0_cyc_i (mc[0]),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_adr_i (madr[1]),
        .m1_dat_i (mdat[1]),
        .m1_sel_i (msel[1]),
        .m1_we_i  (mwe[1]),
        .m1_stb_i (ms[1]),
        .m1_cyc_i (mc[1]),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),
        .s_dat_i  (sdat),
        .s_ack_i  (sack),
        .grant_o  (grant_o)
    );

    typedef struct {
        logic [1:0]  grant;
        logic        s_cyc;
        logic        s_stb;
        logic [31:0] s_adr;
        logic [31:0] s_dat;
        logic [4:0]  s_selwe;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, who was served last, and how many
    // consecutive strobe cycles have gone unanswered.
    int   owner;
    int   last;
    int   stall;
    logic pc [2];
    logic ps [2];
    logic pack, perr;
    logic [1:0] last_ack, last_err;

    // Random master engine state.
    bit active [2];
    int left   [2];

    int m0_err_seen, m0_ack_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("grant", 32'(grant_o), 32'(e.grant));
            chk("s_cyc", 32'(s_cyc_o), 32'(e.s_cyc));
            chk("s_stb", 32'(s_stb_o), 32'(e.s_stb));
            chk("s_adr", s_adr_o, e.s_adr);
            chk("s_dat", s_dat_o, e.s_dat);
            chk("s_selwe", 32'({s_sel_o, s_we_o}), 32'(e.s_selwe));
            chk("ack", 32'({m1_ack_o, m0_ack_o}), 32'(e.ack));
            chk("err", 32'({m1_err_o, m0_err_o}), 32'(e.err));
            chk("m0_dat", m0_dat_o, e.d0);
            chk("m1_dat", m1_dat_o, e.d1);
            if (m0_err_o) m0_err_seen++;
            if (m0_ack_o) m0_ack_seen++;
        end
    end

    task automatic model_reset();
        owner = -1;
        last  = 1;
        stall = 0;
        for (int i = 0; i < 2; i++) begin
            pc[i] = 1'b0; ps[i] = 1'b0; mc[i] = 1'b0; ms[i] = 1'b0;
            active[i] = 1'b0; left[i] = 0;
        end
        pack = 1'b0; perr = 1'b0; sack = 1'b0;
        last_ack = '0; last_err = '0;
    endtask

    // Advance to the next cycle and apply the arbitration rules to what the
    // bus looked like during the cycle just ended.
    task automatic tick_begin();
        @(posedge clk);
        #1;
        if (owner < 0) begin
            if (pc[0] && pc[1]) owner = (last == 1) ? 0 : 1;
            else if (pc[0])     owner = 0;
            else if (pc[1])     owner = 1;
            stall = 0;
        end else if (!pc[owner]) begin
            last  = owner;
            owner = -1;
            stall = 0;
        end else if (ps[owner] && !pack && !perr) begin
            stall++;
        end else begin
            stall = 0;
        end
    endtask

    task automatic tick_end(input logic c0, input logic s0, input logic c1, input logic s1,
                            input logic ackreq);
        exp_t e;
        logic oc, os, a, er;
        mc[0] = c0; ms[0] = s0; mc[1] = c1; ms[1] = s1;
        sdat  = $urandom;
        oc = (owner >= 0) ? mc[owner] : 1'b0;
        os = (owner >= 0) ? ms[owner] : 1'b0;
        a  = ackreq && oc && os;
        er = oc && os && (stall == T) && !a;
        sack = a;
        e.grant   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e.s_cyc   = oc;
        e.s_stb   = os && !er;
        e.s_adr   = (owner >= 0) ? madr[owner] : 32'h0;
        e.s_dat   = (owner >= 0) ? mdat[owner] : 32'h0;
        e.s_selwe = (owner >= 0) ? {msel[owner], mwe[owner]} : 5'h0;
        e.ack     = {a && owner == 1, a && owner == 0};
        e.err     = {er && owner == 1, er && owner == 0};
        e.d0      = (owner == 0) ? sdat : 32'h0;
        e.d1      = (owner == 1) ? sdat : 32'h0;
        q.push_back(e);
        pc[0] = c0; ps[0] = s0; pc[1] = c1; ps[1] = s1;
        pack = a; perr = er;
        last_ack = e.ack; last_err = e.err;
    endtask

    // Masters start cycles of lmin..lmax transfers, each ended by ack or err,
    // then drop cyc for at least one cycle.
    task automatic run_phase(input int n, input logic [1:0] mask, input int start_pct,
                             input int stb_pct, input int ack_pct, input int lmin,
                             input int lmax);
        logic st [2];
        for (int k = 0; k < n; k++) begin
            tick_begin();
            for (int i = 0; i < 2; i++) begin
                if (active[i]) begin
                    if (last_ack[i] || last_err[i]) begin
                        left[i]--;
                        if (left[i] == 0) active[i] = 1'b0;
                    end
                end else if (mask[i] && ($urandom % 100) < start_pct) begin
                    active[i] = 1'b1;
                    left[i]   = $urandom_range(lmax, lmin);
                end
                madr[i] = $urandom;
                mdat[i] = $urandom;
                msel[i] = 4'($urandom);
                mwe[i]  = 1'($urandom);
                st[i]   = active[i] && (($urandom % 100) < stb_pct);
            end
            tick_end(active[0], st[0], active[1], st[1], ($urandom % 100) < ack_pct);
        end
    endtask

    task automatic drain();
        run_phase(40, 2'b00, 0, 100, 100, 1, 1);
    endtask

    initial begin
        logic done;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            madr[i] = '0; mdat[i] = '0; msel[i] = '0; mwe[i] = 1'b0;
        end
        sdat = '0;
        model_reset();
        #3;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset, then alternating single-transfer requests.
        run_phase(16, 2'b11, 100, 100, 100, 1, 1);
        drain();

        // Single master write, slave acking one cycle after stb.
        madr[0] = 32'h1; mdat[0] = 32'h1; msel[0] = 4'hf; mwe[0] = 1'b1;
        tick_begin(); tick_end(1, 1, 0, 0, 0);
        tick_begin(); tick_end(1, 1, 0, 0, 0);
        tick_begin(); tick_end(1, 1, 0, 0, 1);
        tick_begin(); tick_end(0, 0, 0, 0, 0);
        tick_begin(); tick_end(0, 0, 0, 0, 0);

        // Held grant: m1 runs 4 reads while m0 waits.
        run_phase(1, 2'b10, 100, 100, 100, 4, 4);
        run_phase(14, 2'b11, 100, 100, 100, 1, 1);
        drain();

        // Timeout: no ack ever; exactly one err in 8 strobe cycles.
        m0_err_seen = 0; m0_ack_seen = 0;
        repeat (9) begin tick_begin(); tick_end(1, 1, 0, 0, 0); end
        repeat (2) begin tick_begin(); tick_end(0, 0, 0, 0, 0); end
        @(negedge clk); #1;
        chk("timeout_err_count", 32'(m0_err_seen), 32'd1);
        chk("timeout_ack_count", 32'(m0_ack_seen), 32'd0);

        // Ack arriving in the cycle the watchdog would fire.
        m0_err_seen = 0; m0_ack_seen = 0;
        done = 1'b0;
        repeat (10) begin
            logic a;
            tick_begin();
            a = !done && owner == 0 && stall == T;
            tick_end(!done, !done, 0, 0, a);
            if (a) done = 1'b1;
        end
        @(negedge clk); #1;
        chk("collide_ack_count", 32'(m0_ack_seen), 32'd1);
        chk("collide_err_count", 32'(m0_err_seen), 32'd0);

        // Reset while m1 holds the bus with stb high.
        tick_begin(); tick_end(0, 0, 1, 1, 0);
        tick_begin(); tick_end(0, 0, 1, 1, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", 32'(grant_o), 32'h0);
        chk("midrst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("midrst_s_stb", 32'(s_stb_o), 32'h0);
        chk("midrst_m1_dat", m1_dat_o, 32'h0);
        model_reset();
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick_begin(); tick_end(1, 1, 1, 1, 0);
        tick_begin(); tick_end(1, 1, 1, 1, 0);
        @(negedge clk); #1;
        chk("postrst_tie_grant", 32'(grant_o), 32'h1);
        tick_begin(); tick_end(0, 0, 0, 0, 0);
        tick_begin(); tick_end(0, 0, 0, 0, 0);

        // Randomized traffic, including stalled-slave stretches.
        run_phase(400, 2'b11, 30, 80, 50, 1, 4);
        run_phase(300, 2'b11, 50, 90, 0, 1, 2);
        run_phase(400, 2'b11, 20, 60, 70, 1, 3);
        drain();

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
